// File: rtl/demux4_stream.sv
// -----------------------------------------------------------------------------
// demux4_stream
//
// Purpose:
//   1-to-4 stream demultiplexer. A single valid/ready input stream carries a
//   2-bit destination select. Each word is routed into one of four
//   single-entry output slots. Every slot has its own valid/ready handshake,
//   so a stalled consumer blocks only its own channel.
//
// Optional feature (macro DEMUX4_CNT_EN):
//   When the macro is defined, a per-channel completed-transfer counter is
//   added and exported on cnt_o. It wraps modulo 2^CNT_W. When the macro is
//   undefined, the cnt_o port and the counters do not exist.
//
// Parameters:
//   WIDTH  data word width (>= 1)
//   CNT_W  per-channel transfer counter width (only used with DEMUX4_CNT_EN)
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_n_i  in   asynchronous active-low reset
//   data_i   in   input word
//   sel_i    in   destination channel for data_i
//   valid_i  in   input word valid
//   ready_o  out  input word can be accepted this cycle
//   data_o   out  packed channel data, channel n at [n*WIDTH +: WIDTH]
//   valid_o  out  per-channel output valid
//   ready_i  in   per-channel consumer ready
//   busy_o   out  OR of valid_o
//   cnt_o    out  per-channel drain counters (DEMUX4_CNT_EN only)
// -----------------------------------------------------------------------------
module demux4_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [1:0]         sel_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [4*WIDTH-1:0] data_o,
    output logic [3:0]         valid_o,
    input  logic [3:0]         ready_i,
    output logic               busy_o
`ifdef DEMUX4_CNT_EN
    ,
    output logic [4*CNT_W-1:0] cnt_o
`endif
);

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 1) begin : g_bad_width
        $error("demux4_stream: WIDTH must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("demux4_stream: CNT_W must be >= 1");
    end

    logic [3:0]       valid_q;
    logic [3:0]       valid_d;
    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];

    logic       accept;
    logic [3:0] drain;
    logic [3:0] load;

    // ready_o looks only at the slot currently addressed by sel_i; a slot
    // that drains this cycle can be refilled in the same cycle. valid_i is
    // deliberately kept out of this path.
    assign ready_o = ~valid_q[sel_i] | ready_i[sel_i];
    assign accept  = valid_i & ready_o;
    assign drain   = valid_q & ready_i;

    for (genvar n = 0; n < 4; n++) begin : g_slot
        assign load[n] = accept & (sel_i == 2'(n));

        // Accept wins over drain: a simultaneous drain and refill keeps the
        // slot full with the new word (no bubble). A plain drain empties the
        // slot but keeps the old data visible.
        always_comb begin
            valid_d[n] = valid_q[n];
            data_d[n]  = data_q[n];
            if (load[n]) begin
                valid_d[n] = 1'b1;
                data_d[n]  = data_i;
            end else if (drain[n]) begin
                valid_d[n] = 1'b0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                valid_q[n] <= 1'b0;
                data_q[n]  <= '0;
            end else begin
                valid_q[n] <= valid_d[n];
                data_q[n]  <= data_d[n];
            end
        end

        assign data_o[n*WIDTH +: WIDTH] = data_q[n];
    end

    assign valid_o = valid_q;
    assign busy_o  = |valid_q;

`ifdef DEMUX4_CNT_EN
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    for (genvar n = 0; n < 4; n++) begin : g_cnt
        // Natural modulo-2^CNT_W wrap on overflow.
        always_comb begin
            cnt_d[n] = cnt_q[n];
            if (drain[n]) begin
                cnt_d[n] = cnt_q[n] + 1'b1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                cnt_q[n] <= '0;
            end else begin
                cnt_q[n] <= cnt_d[n];
            end
        end

        assign cnt_o[n*CNT_W +: CNT_W] = cnt_q[n];
    end
`endif

endmodule

// File: tb/tb_demux4_stream.sv
module tb_demux4_stream;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic               clk_i;
    logic               rst_n_i;
    logic [WIDTH-1:0]   data_i;
    logic [1:0]         sel_i;
    logic               valid_i;
    logic               ready_o;
    logic [4*WIDTH-1:0] data_o;
    logic [3:0]         valid_o;
    logic [3:0]         ready_i;
    logic               busy_o;
`ifdef DEMUX4_CNT_EN
    logic [4*CNT_W-1:0] cnt_o;
`endif

    int ncmp  = 0;
    int nfail = 0;

    demux4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .data_i  (data_i),
        .sel_i   (sel_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .busy_o  (busy_o)
`ifdef DEMUX4_CNT_EN
        ,
        .cnt_o   (cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d);
        valid_i = v;
        sel_i   = s;
        data_i  = d;
        #1;
    endtask

    initial begin
        rst_n_i = 1'b0;
        data_i  = '0;
        sel_i   = 2'd0;
        valid_i = 1'b0;
        ready_i = 4'b0000;
        #1;
        chk("rst_valid", 64'(valid_o), 64'h0);
        chk("rst_data",  64'(data_o),  64'h0);
        chk("rst_busy",  64'(busy_o),  64'h0);
        chk("rst_ready", 64'(ready_o), 64'h1);
`ifdef DEMUX4_CNT_EN
        chk("rst_cnt",   64'(cnt_o),   64'h0);
`endif
        @(negedge clk_i);
        rst_n_i = 1'b1;
        step();

        // Routing: one word per channel, all consumers ready.
        ready_i = 4'b1111;
        drive(1'b1, 2'd0, 8'hAA);
        chk("route_ready0", 64'(ready_o), 64'h1);
        step();
        chk("route_v0", 64'(valid_o), 64'h1);
        chk("route_d0", 64'(data_o[7:0]), 64'hAA);
        drive(1'b1, 2'd1, 8'hBB);
        chk("route_ready1", 64'(ready_o), 64'h1);
        step();
        chk("route_v1", 64'(valid_o), 64'h2);
        chk("route_d1", 64'(data_o[15:8]), 64'hBB);
        drive(1'b1, 2'd2, 8'hCC);
        chk("route_ready2", 64'(ready_o), 64'h1);
        step();
        chk("route_v2", 64'(valid_o), 64'h4);
        chk("route_d2", 64'(data_o[23:16]), 64'hCC);
        drive(1'b1, 2'd3, 8'hDD);
        chk("route_ready3", 64'(ready_o), 64'h1);
        step();
        chk("route_v3", 64'(valid_o), 64'h8);
        chk("route_d3", 64'(data_o[31:24]), 64'hDD);
        chk("route_busy", 64'(busy_o), 64'h1);
        drive(1'b0, 2'd0, 8'h00);
        step();
        chk("route_idle_v", 64'(valid_o), 64'h0);
        chk("route_idle_busy", 64'(busy_o), 64'h0);
        chk("route_hold_data", 64'(data_o), 64'hDDCCBBAA);

        // Backpressure on channel 2.
        ready_i = 4'b1011;
        drive(1'b1, 2'd2, 8'h11);
        chk("bp_ready_empty", 64'(ready_o), 64'h1);
        step();
        chk("bp_v_full", 64'(valid_o), 64'h4);
        chk("bp_d_11", 64'(data_o[23:16]), 64'h11);
        drive(1'b1, 2'd2, 8'h22);
        chk("bp_ready_blocked", 64'(ready_o), 64'h0);
        step();
        chk("bp_v_stall", 64'(valid_o), 64'h4);
        chk("bp_d_stable", 64'(data_o[23:16]), 64'h11);
        chk("bp_ready_still0", 64'(ready_o), 64'h0);
        ready_i = 4'b1111;
        #1;
        chk("bp_ready_release", 64'(ready_o), 64'h1);
        step();
        chk("bp_v_refill", 64'(valid_o), 64'h4);
        chk("bp_d_22", 64'(data_o[23:16]), 64'h22);
        drive(1'b0, 2'd0, 8'h00);
        step();
        chk("bp_drained", 64'(valid_o), 64'h0);

        // Independence: channel 0 stalled while channels 1 and 3 flow.
        ready_i = 4'b1110;
        drive(1'b1, 2'd0, 8'h55);
        step();
        chk("ind_ch0_full", 64'(valid_o), 64'h1);
        drive(1'b1, 2'd0, 8'h99);
        chk("ind_ch0_block", 64'(ready_o), 64'h0);
        drive(1'b1, 2'd1, 8'h33);
        chk("ind_ready1", 64'(ready_o), 64'h1);
        step();
        chk("ind_v_01", 64'(valid_o), 64'h3);
        chk("ind_d1", 64'(data_o[15:8]), 64'h33);
        drive(1'b1, 2'd3, 8'h44);
        chk("ind_ready3", 64'(ready_o), 64'h1);
        step();
        chk("ind_v_03", 64'(valid_o), 64'h9);
        chk("ind_d3", 64'(data_o[31:24]), 64'h44);
        drive(1'b0, 2'd0, 8'h00);
        step();
        chk("ind_v_0", 64'(valid_o), 64'h1);
        chk("ind_d0_held", 64'(data_o[7:0]), 64'h55);

        // Pass-through: eight back-to-back words on channel 3, no bubble.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'd3, 8'(8'h60 + i));
            chk("pt_ready", 64'(ready_o), 64'h1);
            step();
            chk("pt_valid", 64'(valid_o), 64'h9);
            chk("pt_data", 64'(data_o[31:24]), 64'(8'h60 + i));
        end
        drive(1'b0, 2'd0, 8'h00);
        step();
        chk("pt_end_v", 64'(valid_o), 64'h1);

        // Reset mid-operation with channels 0 and 1 full.
        ready_i = 4'b0000;
        drive(1'b1, 2'd1, 8'h77);
        step();
        chk("mid_pre_v", 64'(valid_o), 64'h3);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("mid_rst_v", 64'(valid_o), 64'h0);
        chk("mid_rst_d", 64'(data_o), 64'h0);
        chk("mid_rst_ready", 64'(ready_o), 64'h1);
        chk("mid_rst_busy", 64'(busy_o), 64'h0);
        valid_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        step();
        chk("mid_post_v", 64'(valid_o), 64'h0);

`ifdef DEMUX4_CNT_EN
        // 17 drains on channel 1 with a 4-bit counter wrap to 1.
        ready_i = 4'b0010;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 2'd1, 8'(i));
            step();
        end
        drive(1'b0, 2'd0, 8'h00);
        step();
        chk("cnt_wrap", 64'(cnt_o), 64'h0010);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
